rx_crc_ctrl: RTL and testbench

Sequencing controller for the receive-side CRC datapath. It drives the 64-bit-per-cycle CRC engine for the frame body, then the byte-serial CRC engine for the 0-7 residual bytes of the terminating word. It compares the final residue with the CRC-32 magic constant and reports one pass/fail pulse per frame. It sits between the rx frame decoder (receiving, get_terminator, terminator_location) and the two CRC engines.

---
 rtl/rx_crc_ctrl.sv | 156 +++++++++++++++
 tb/tb_rx_crc_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/rx_crc_ctrl.sv
// Receive-side CRC sequencer: runs the 64-bit engine over the frame body, the
// byte engine over the residual tail bytes, then reports one pass/fail pulse.
module rx_crc_ctrl #(
  parameter int unsigned PIPE_LAT = 2,
  parameter logic [31:0] MAGIC    = 32'hc704dd7b
) (
  input  logic        rxclk,
  input  logic        reset,
  input  logic        receiving,
  input  logic        get_terminator,
  input  logic [2:0]  terminator_location,
  input  logic [31:0] crc64_out,
  input  logic [31:0] crc8_out,
  output logic        crc64_start,
  output logic        crc64_init,
  output logic        crc8_load,
  output logic        crc8_start,
  output logic [2:0]  tail_byte_sel,
  output logic        busy,
  output logic        crc_check_valid,
  output logic        crc_check_invalid,
  output logic [2:0]  o_dbg_state
);

  localparam logic [2:0] LP_FLUSH_LOAD = 3'(PIPE_LAT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BODY  = 3'd1,
    S_FLUSH = 3'd2,
    S_TAIL  = 3'd3,
    S_CHECK = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_rise_det;
  logic [2:0]  r_bytes_left;
  logic [2:0]  r_flush_cnt;
  logic [2:0]  r_sel;
  logic        r_tail;
  logic        r_abort;
  logic        w_start;
  logic [31:0] w_residue;

  // Gated by reset so no strobe escapes while reset is held with receiving high.
  assign w_start     = reset & receiving & ~r_rise_det;
  assign w_residue   = r_tail ? crc8_out : crc64_out;
  assign o_dbg_state = r_state;

  always_ff @(posedge rxclk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge rxclk or negedge reset) begin
    if (!reset) begin
      r_rise_det   <= 1'b0;
      r_bytes_left <= 3'd0;
      r_flush_cnt  <= 3'd0;
      r_sel        <= 3'd0;
      r_tail       <= 1'b0;
      r_abort      <= 1'b0;
    end else begin
      r_rise_det <= receiving;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_tail  <= 1'b0;
            r_abort <= 1'b0;
          end
        end
        S_BODY: begin
          if (get_terminator) begin
            r_bytes_left <= terminator_location;
            r_flush_cnt  <= LP_FLUSH_LOAD;
          end else if (!receiving) begin
            r_abort <= 1'b1;
          end
        end
        S_FLUSH: begin
          r_flush_cnt <= r_flush_cnt - 3'd1;
          r_sel       <= 3'd0;
        end
        S_TAIL: begin
          r_tail       <= 1'b1;
          r_sel        <= r_sel + 3'd1;
          r_bytes_left <= r_bytes_left - 3'd1;
        end
        default: ;
      endcase
    end
  end

  // All engine strobes are level enables for the current cycle; the check
  // outputs are single-cycle pulses with no handshake back from the consumer.
  always_comb begin
    w_next            = r_state;
    crc64_start       = 1'b0;
    crc64_init        = 1'b0;
    crc8_load         = 1'b0;
    crc8_start        = 1'b0;
    tail_byte_sel     = 3'd0;
    busy              = 1'b0;
    crc_check_valid   = 1'b0;
    crc_check_invalid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          crc64_init  = 1'b1;
          crc64_start = 1'b1;
          w_next      = S_BODY;
        end
      end
      S_BODY: begin
        busy = 1'b1;
        if (get_terminator) begin
          w_next = S_FLUSH;
        end else if (!receiving) begin
          w_next = S_CHECK;
        end else begin
          crc64_start = 1'b1;
        end
      end
      S_FLUSH: begin
        busy      = 1'b1;
        crc8_load = 1'b1;
        if (r_flush_cnt == 3'd1) begin
          w_next = (r_bytes_left != 3'd0) ? S_TAIL : S_CHECK;
        end
      end
      S_TAIL: begin
        busy          = 1'b1;
        crc8_start    = 1'b1;
        tail_byte_sel = r_sel;
        if (r_bytes_left == 3'd1) begin
          w_next = S_CHECK;
        end
      end
      S_CHECK: begin
        busy = 1'b1;
        if (!r_abort && (w_residue == MAGIC)) begin
          crc_check_valid = 1'b1;
        end else begin
          crc_check_invalid = 1'b1;
        end
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_rx_crc_ctrl.sv
// Bench for rx_crc_ctrl: frame driver, per-cycle output trace, and a check-pulse
// scoreboard fed by a frame-level model of latency and residue selection.
module tb_rx_crc_ctrl;

  localparam int          P     = 2;
  localparam logic [31:0] MAGIC = 32'hc704dd7b;
  localparam int          TRW   = 4096;

  logic        rxclk = 1'b0;
  logic        reset = 1'b0;
  logic        receiving = 1'b0;
  logic        get_terminator = 1'b0;
  logic [2:0]  terminator_location = 3'd0;
  logic [31:0] crc64_out = 32'd0;
  logic [31:0] crc8_out = 32'd0;
  logic        crc64_start, crc64_init, crc8_load, crc8_start;
  logic [2:0]  tail_byte_sel;
  logic        busy, crc_check_valid, crc_check_invalid;
  logic [2:0]  o_dbg_state;

  rx_crc_ctrl #(.PIPE_LAT(P), .MAGIC(MAGIC)) dut (
    .rxclk(rxclk), .reset(reset), .receiving(receiving),
    .get_terminator(get_terminator), .terminator_location(terminator_location),
    .crc64_out(crc64_out), .crc8_out(crc8_out),
    .crc64_start(crc64_start), .crc64_init(crc64_init),
    .crc8_load(crc8_load), .crc8_start(crc8_start),
    .tail_byte_sel(tail_byte_sel), .busy(busy),
    .crc_check_valid(crc_check_valid), .crc_check_invalid(crc_check_invalid),
    .o_dbg_state(o_dbg_state)
  );

  // Clock and cycle index
  always #5 rxclk = ~rxclk;
  int cyc = 0;
  always @(posedge rxclk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  // Entry: {pulse cycle[31:0], valid, invalid}
  logic [33:0] exp_q[$];
  logic        tr_init[TRW], tr_s64[TRW], tr_load[TRW], tr_s8[TRW], tr_busy[TRW];
  logic [2:0]  tr_sel[TRW];
  logic [2:0]  tr_state[TRW];
  logic [33:0] mon_e;

  function automatic void chk(string name, int c, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", name, c, act, exp);
    end
  endfunction

  // Monitor: trace every cycle mid-period, score each check pulse
  always @(negedge rxclk) begin
    tr_init[cyc % TRW]  = crc64_init;
    tr_s64[cyc % TRW]   = crc64_start;
    tr_load[cyc % TRW]  = crc8_load;
    tr_s8[cyc % TRW]    = crc8_start;
    tr_busy[cyc % TRW]  = busy;
    tr_sel[cyc % TRW]   = tail_byte_sel;
    tr_state[cyc % TRW] = o_dbg_state;
    if (crc_check_valid || crc_check_invalid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse cycle=%0d got=%0b%0b want=none", cyc,
                 crc_check_valid, crc_check_invalid);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pulse_cycle", cyc, 32'(cyc), mon_e[33:2]);
        chk("pulse_kind", cyc, 32'({crc_check_valid, crc_check_invalid}), 32'(mon_e[1:0]));
      end
    end
  end

  task automatic step();
    @(posedge rxclk);
    #1;
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, "_init"}, cyc, 32'(crc64_init), 32'd0);
    chk({tag, "_s64"}, cyc, 32'(crc64_start), 32'd0);
    chk({tag, "_load"}, cyc, 32'(crc8_load), 32'd0);
    chk({tag, "_s8"}, cyc, 32'(crc8_start), 32'd0);
    chk({tag, "_sel"}, cyc, 32'(tail_byte_sel), 32'd0);
    chk({tag, "_busy"}, cyc, 32'(busy), 32'd0);
    chk({tag, "_pulse"}, cyc, 32'({crc_check_valid, crc_check_invalid}), 32'd0);
  endtask

  // Expected strobes for a frame: start at r, terminator at t, n tail bytes
  task automatic check_trace(int r, int t, int n, int last);
    int i;
    bit e_s8;
    int e_sel;
    for (int c = r - 1; c <= last; c++) begin
      i     = c % TRW;
      e_s8  = (c > t + P) && (c <= t + P + n);
      e_sel = e_s8 ? (c - (t + P + 1)) : 0;
      chk("init", c, 32'(tr_init[i]), 32'(c == r));
      chk("crc64_start", c, 32'(tr_s64[i]), 32'((c >= r) && (c < t)));
      chk("busy", c, 32'(tr_busy[i]), 32'((c > r) && (c <= t + P + n + 1)));
      chk("crc8_load", c, 32'(tr_load[i]), 32'((c > t) && (c <= t + P)));
      chk("crc8_start", c, 32'(tr_s8[i]), 32'(e_s8));
      chk("tail_byte_sel", c, 32'(tr_sel[i]), 32'(e_sel));
    end
  endtask

  task automatic run_frame(int bw, int n, logic [31:0] c8, logic [31:0] c64, bit hold, bit glitch);
    int r, t, last;
    logic ok;
    crc8_out  = c8;
    crc64_out = c64;
    receiving = 1'b1;
    r = cyc;
    repeat (bw) step();
    get_terminator      = 1'b1;
    terminator_location = 3'(n);
    t  = cyc;
    ok = (((n != 0) ? c8 : c64) == MAGIC);
    exp_q.push_back({32'(t + P + n + 1), ok, ~ok});
    step();
    get_terminator      = glitch;
    terminator_location = 3'($urandom_range(0, 7));
    if (!hold) receiving = 1'b0;
    step();
    get_terminator = 1'b0;
    last = t + P + n + 3;
    while (cyc <= last) step();
    receiving = 1'b0;
    check_trace(r, t, n, last);
    chk("queue_drained", cyc, 32'(exp_q.size()), 32'd0);
    step();
    step();
  endtask

  task automatic run_abort();
    int r, a;
    receiving = 1'b1;
    r = cyc;
    repeat (3) step();
    receiving = 1'b0;
    a = cyc;
    exp_q.push_back({32'(a + 1), 2'b01});
    step();
    step();
    get_terminator      = 1'b1;
    terminator_location = 3'd3;
    step();
    get_terminator = 1'b0;
    repeat (6) step();
    chk("abort_s64_drop", a, 32'(tr_s64[a % TRW]), 32'd0);
    chk("abort_busy_body", a, 32'(tr_busy[a % TRW]), 32'd1);
    chk("abort_idle", a + 2, 32'(tr_state[(a + 2) % TRW]), 32'd0);
    for (int c = a + 2; c <= a + 8; c++) begin
      chk("abort_busy", c, 32'(tr_busy[c % TRW]), 32'd0);
      chk("abort_load", c, 32'(tr_load[c % TRW]), 32'd0);
      chk("abort_s8", c, 32'(tr_s8[c % TRW]), 32'd0);
      chk("abort_init", c, 32'(tr_init[c % TRW]), 32'd0);
    end
    chk("abort_queue", cyc, 32'(exp_q.size()), 32'd0);
    step();
  endtask

  task automatic run_reset_in_tail();
    int t;
    crc8_out  = MAGIC;
    crc64_out = 32'd0;
    receiving = 1'b1;
    repeat (3) step();
    get_terminator      = 1'b1;
    terminator_location = 3'd5;
    t = cyc;
    exp_q.push_back({32'(t + P + 6), 2'b10});
    step();
    get_terminator = 1'b0;
    receiving      = 1'b0;
    while (cyc < t + P + 2) step();
    chk("tail_before_rst", cyc, 32'(crc8_start), 32'd1);
    reset     = 1'b0;
    receiving = 1'b1;
    void'(exp_q.pop_back());
    #1;
    check_all_zero("rst_tail");
    repeat (3) step();
    receiving = 1'b0;
    step();
    reset = 1'b1;
    step();
    step();
    run_frame(7, 4, MAGIC, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    int bw, n;
    logic [31:0] c8, c64;
    reset     = 1'b0;
    receiving = 1'b1;
    repeat (3) step();
    @(negedge rxclk);
    check_all_zero("reset");
    step();
    receiving = 1'b0;
    step();
    reset = 1'b1;
    step();
    step();

    run_frame(7, 4, MAGIC, 32'h12345678, 1'b0, 1'b0);
    run_frame(5, 0, 32'h0badf00d, MAGIC, 1'b0, 1'b0);
    run_frame(3, 0, MAGIC, 32'h00000000, 1'b0, 1'b0);
    run_frame(4, 7, 32'hdeadbeef, MAGIC, 1'b0, 1'b0);
    run_frame(2, 3, MAGIC, 32'h0, 1'b1, 1'b1);
    run_frame(1, 1, MAGIC, 32'h0, 1'b0, 1'b0);
    run_abort();
    run_reset_in_tail();

    for (int k = 0; k < 30; k++) begin
      bw  = $urandom_range(1, 10);
      n   = $urandom_range(0, 7);
      c8  = ($urandom_range(0, 1) == 1) ? MAGIC : $urandom;
      c64 = ($urandom_range(0, 1) == 1) ? MAGIC : $urandom;
      run_frame(bw, n, c8, c64, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (5) step();
    chk("final_queue", cyc, 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
